// File: rtl/dmem_arbiter.sv
// Shares the single-port sync-read data RAM between CPU MEM stage and DMA; CPU priority, DMA starvation bound.
// Grant is combinational in N, RAM command registered for N+1, load data at N+2; a losing requester holds its request.
module dmem_arbiter #(
   parameter int ADDR_W   = 10,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [31:0]       cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_gnt,
   output logic              dma_rvalid,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef struct packed {
      logic vld;
      logic dma;
   } tag_t;

   localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

   logic [3:0]        dma_wait_q, dma_wait_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   tag_t              tag1_q, tag1_d;
   tag_t              tag2_q, tag2_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
   logic              dma_prio;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0]};

   always_comb begin
      dma_prio = dma_req & (dma_wait_q == WAIT_LIM);
      cpu_gnt  = reset_n & cpu_req & ~dma_prio;
      dma_gnt  = reset_n & dma_req & (~cpu_req | dma_prio);

      dma_wait_d = 4'd0;
      if (dma_req & ~dma_gnt)
         dma_wait_d = (dma_wait_q >= WAIT_LIM) ? WAIT_LIM : dma_wait_q + 4'd1;

      mem_en_d    = cpu_gnt | dma_gnt;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if (dma_gnt) begin
         mem_we_d    = dma_we;
         mem_addr_d  = dma_addr;
         mem_wdata_d = dma_wdata;
      end else if (cpu_gnt) begin
         mem_we_d    = cpu_we;
         mem_addr_d  = cpu_addr[ADDR_W+1:2];
         mem_wdata_d = cpu_wdata;
      end

      tag1_d.vld = mem_en_d & ~mem_we_d;
      tag1_d.dma = dma_gnt;
      tag2_d     = tag1_q;

      cpu_rvalid  = tag2_q.vld & ~tag2_q.dma;
      dma_rvalid  = tag2_q.vld & tag2_q.dma;
      cpu_rdata_d = cpu_rvalid ? mem_rdata : cpu_rdata_q;
      dma_rdata_d = dma_rvalid ? mem_rdata : dma_rdata_q;
      cpu_rdata   = cpu_rdata_d;
      dma_rdata   = dma_rdata_d;

      // The returning load no longer stalls: the pipeline captures cpu_rdata in that cycle.
      cpu_stall = reset_n & ((cpu_req & ~cpu_gnt) | (tag1_q.vld & ~tag1_q.dma));
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         dma_wait_q  <= 4'd0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         tag1_q      <= '0;
         tag2_q      <= '0;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
      end else begin
         dma_wait_q  <= dma_wait_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         tag1_q      <= tag1_d;
         tag2_q      <= tag2_d;
         cpu_rdata_q <= cpu_rdata_d;
         dma_rdata_q <= dma_rdata_d;
      end
   end

   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_dmem_arbiter;
   localparam int AW = 10;
   localparam int DW = 32;
   localparam int MW = 4;

   logic clock = 1'b0;
   logic reset_n;
   logic cpu_req, cpu_we, dma_req, dma_we;
   logic [31:0] cpu_addr;
   logic [DW-1:0] cpu_wdata, dma_wdata;
   logic [AW-1:0] dma_addr;
   logic cpu_gnt, cpu_rvalid, cpu_stall, dma_gnt, dma_rvalid;
   logic [DW-1:0] cpu_rdata, dma_rdata;
   logic mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   always #5 clock = ~clock;

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
      .clock(clock), .reset_n(reset_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // Synchronous-read RAM behind the arbiter
   logic [DW-1:0] ram [0:1023];
   always @(posedge clock) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata     <= ram[mem_addr];
      end
   end

   // Reference model: memory contents in grant order plus a queue of pending responses
   typedef struct { int due; bit dma; logic [DW-1:0] data; } rsp_t;
   logic [DW-1:0] gold [0:1023];
   rsp_t rq[$];
   int dwait, cyc;
   int tests_run, tests_failed;
   logic exp_cg, exp_dg, exp_crv, exp_drv, exp_stall, exp_men, exp_mwe;
   logic [AW-1:0] exp_maddr;
   logic [DW-1:0] exp_crd, exp_drd, exp_mwd;

   task automatic model_reset();
      rq.delete();
      dwait = 0;
      exp_crd = '0; exp_drd = '0; exp_men = 1'b0; exp_mwe = 1'b0;
      exp_maddr = '0; exp_mwd = '0;
   endtask

   // Expected outputs for the current cycle, sampled at the falling edge
   task automatic settle();
      @(negedge clock);
      exp_cg = 1'b0; exp_dg = 1'b0; exp_crv = 1'b0; exp_drv = 1'b0; exp_stall = 1'b0;
      if (!reset_n) begin
         model_reset();
      end else begin
         if (cpu_req && dma_req) begin
            if (dwait == MW) exp_dg = 1'b1;
            else             exp_cg = 1'b1;
         end else begin
            exp_cg = cpu_req;
            exp_dg = dma_req;
         end
         if (rq.size() > 0 && rq[0].due == cyc) begin
            if (rq[0].dma) begin exp_drv = 1'b1; exp_drd = rq[0].data; end
            else           begin exp_crv = 1'b1; exp_crd = rq[0].data; end
         end
         exp_stall = cpu_req && !exp_cg;
         foreach (rq[i]) if (!rq[i].dma && rq[i].due == cyc + 1) exp_stall = 1'b1;
      end
   endtask

   task automatic advance();
      int w;
      @(posedge clock);
      if (!reset_n) begin
         model_reset();
      end else begin
         if (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());
         exp_men = exp_cg | exp_dg;
         exp_mwe = 1'b0;
         if (exp_cg) begin
            w = int'(cpu_addr[AW+1:2]);
            exp_mwe = cpu_we; exp_maddr = AW'(w); exp_mwd = cpu_wdata;
            if (cpu_we) gold[w] = cpu_wdata;
            else        rq.push_back('{due: cyc + 2, dma: 1'b0, data: gold[w]});
         end
         if (exp_dg) begin
            w = int'(dma_addr);
            exp_mwe = dma_we; exp_maddr = dma_addr; exp_mwd = dma_wdata;
            if (dma_we) gold[w] = dma_wdata;
            else        rq.push_back('{due: cyc + 2, dma: 1'b1, data: gold[w]});
         end
         if (dma_req && !exp_dg) dwait = (dwait + 1 > MW) ? MW : dwait + 1;
         else                    dwait = 0;
      end
      cyc++;
      #1;
   endtask

   task automatic idle();
      cpu_req = 1'b0; cpu_we = 1'b0; dma_req = 1'b0; dma_we = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; cpu_req = 1'b1; dma_req = 1'b1; cpu_we = 1'b0; dma_we = 1'b0;
      cpu_addr = 32'h0; dma_addr = '0; cpu_wdata = '0; dma_wdata = '0;
      settle();
      tests_run++;
      if ({cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, cpu_stall, mem_en, mem_we} !== 7'b0) begin
         tests_failed++; $display("FAIL reset_strobes: got %b want 0", {cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, cpu_stall, mem_en, mem_we});
      end
      tests_run++;
      if ({mem_addr, mem_wdata, cpu_rdata, dma_rdata} !== '0) begin
         tests_failed++; $display("FAIL reset_data: addr %h wdata %h crd %h drd %h want 0", mem_addr, mem_wdata, cpu_rdata, dma_rdata);
      end
      advance(); idle(); advance();
      reset_n = 1'b1;
   endtask

   task automatic test_store_load();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
      settle();
      tests_run++;
      if ({cpu_gnt, cpu_stall} !== 2'b10) begin
         tests_failed++; $display("FAIL store_gnt: gnt/stall %b want 10", {cpu_gnt, cpu_stall});
      end
      advance();
      cpu_we = 1'b0;
      settle();
      tests_run++;
      if ({cpu_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b111, 10'd4, 32'hDEADBEEF}) begin
         tests_failed++; $display("FAIL store_cmd: gnt %b en %b we %b addr %h wdata %h", cpu_gnt, mem_en, mem_we, mem_addr, mem_wdata);
      end
      advance(); idle();
      settle();
      tests_run++;
      if ({cpu_stall, mem_en, mem_we, cpu_rvalid} !== 4'b1100) begin
         tests_failed++; $display("FAIL load_n1: stall/en/we/rvalid %b want 1100", {cpu_stall, mem_en, mem_we, cpu_rvalid});
      end
      advance();
      settle();
      tests_run++;
      if ({cpu_rvalid, cpu_stall, cpu_rdata} !== {2'b10, 32'hDEADBEEF}) begin
         tests_failed++; $display("FAIL load_n2: rvalid %b stall %b rdata %h want 1 0 deadbeef", cpu_rvalid, cpu_stall, cpu_rdata);
      end
      advance();
   endtask

   task automatic test_dma_burst();
      for (int i = 0; i < 4; i++) begin
         dma_req = 1'b1; dma_we = 1'b1; dma_addr = AW'(i); dma_wdata = 32'hA0 + 32'(i);
         settle();
         tests_run++;
         if ({dma_gnt, cpu_gnt} !== 2'b10) begin
            tests_failed++; $display("FAIL dma_wr_gnt%0d: dma/cpu gnt %b want 10", i, {dma_gnt, cpu_gnt});
         end
         advance();
      end
      for (int k = 0; k < 6; k++) begin
         if (k < 4) begin dma_req = 1'b1; dma_we = 1'b0; dma_addr = AW'(k); end
         else idle();
         settle();
         if (k < 4) begin
            tests_run++;
            if (dma_gnt !== 1'b1) begin tests_failed++; $display("FAIL dma_rd_gnt%0d: got %b want 1", k, dma_gnt); end
         end
         if (k >= 2) begin
            tests_run++;
            if ({dma_rvalid, cpu_rvalid, dma_rdata} !== {2'b10, 32'hA0 + 32'(k - 2)}) begin
               tests_failed++; $display("FAIL dma_rd_data%0d: rvalid %b cpu_rvalid %b data %h want %h", k - 2, dma_rvalid, cpu_rvalid, dma_rdata, 32'hA0 + 32'(k - 2));
            end
         end
         advance();
      end
   endtask

   task automatic test_contention();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'h1234_5678;
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 10'd20; dma_wdata = 32'h5555_AAAA;
      settle();
      tests_run++;
      if ({cpu_gnt, dma_gnt} !== 2'b10) begin
         tests_failed++; $display("FAIL contend_c0: cpu/dma gnt %b want 10", {cpu_gnt, dma_gnt});
      end
      advance(); cpu_req = 1'b0;
      settle();
      tests_run++;
      if ({cpu_gnt, dma_gnt, dut.dma_wait_q} !== {2'b01, 4'd1}) begin
         tests_failed++; $display("FAIL contend_c1: gnt %b dma_wait %0d want 01 / 1", {cpu_gnt, dma_gnt}, dut.dma_wait_q);
      end
      advance(); idle();
      settle();
      tests_run++;
      if (dut.dma_wait_q !== 4'd0) begin
         tests_failed++; $display("FAIL contend_clear: dma_wait %0d want 0", dut.dma_wait_q);
      end
      advance();
   endtask

   task automatic test_starvation();
      int n_ops = 0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; cpu_wdata = '0;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 10'd3;
      for (int k = 0; k < 9; k++) begin
         settle();
         if (k < 6) begin
            tests_run++;
            if (k == 4) begin
               if ({cpu_gnt, dma_gnt, cpu_stall} !== 3'b011) begin
                  tests_failed++; $display("FAIL starve_c4: cpu/dma gnt/stall %b want 011", {cpu_gnt, dma_gnt, cpu_stall});
               end
            end else if ({cpu_gnt, dma_gnt} !== 2'b10) begin
               tests_failed++; $display("FAIL starve_c%0d: cpu/dma gnt %b want 10", k, {cpu_gnt, dma_gnt});
            end
         end
         tests_run++;
         if ({cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata} !== {exp_crv, exp_drv, exp_crd, exp_drd}) begin
            tests_failed++; $display("FAIL starve_ret%0d: rv %b%b data %h %h want %b%b %h %h", k, cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata, exp_crv, exp_drv, exp_crd, exp_drd);
         end
         if (exp_cg) n_ops++;
         advance();
         if (k == 4) dma_req = 1'b0;
         if (k >= 5) idle();
         else if (exp_cg) begin
            cpu_we = n_ops[0]; cpu_addr = n_ops[0] ? 32'h20 : 32'h10; cpu_wdata = $urandom;
         end
      end
   endtask

   task automatic test_interleave();
      for (int k = 0; k < 5; k++) begin
         idle();
         if (k == 0) begin cpu_req = 1'b1; cpu_addr = 32'h10; end
         if (k == 1) begin dma_req = 1'b1; dma_addr = 10'd1; end
         if (k == 2) begin cpu_req = 1'b1; cpu_addr = 32'h8; end
         settle();
         if (k >= 2) begin
            tests_run++;
            if (k == 3) begin
               if ({cpu_rvalid, dma_rvalid, dma_rdata} !== {2'b01, 32'hA1}) begin
                  tests_failed++; $display("FAIL ilv_dma: rv %b%b data %h want 01 a1", cpu_rvalid, dma_rvalid, dma_rdata);
               end
            end else if ({cpu_rvalid, dma_rvalid, cpu_rdata} !== {2'b10, (k == 2) ? 32'hDEADBEEF : 32'hA2}) begin
               tests_failed++; $display("FAIL ilv_cpu%0d: rv %b%b data %h", k, cpu_rvalid, dma_rvalid, cpu_rdata);
            end
         end
         advance();
      end
   endtask

   task automatic test_reset_midload();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
      settle(); advance(); idle();
      reset_n = 1'b0;
      settle();
      tests_run++;
      if ({cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, cpu_stall, mem_en, mem_addr} !== '0) begin
         tests_failed++; $display("FAIL midrst_outs: strobes %b addr %h want 0", {cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, cpu_stall, mem_en}, mem_addr);
      end
      advance(); reset_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         if (k == 1) begin cpu_req = 1'b1; cpu_addr = 32'h4; end
         else idle();
         settle();
         tests_run++;
         if (k == 3) begin
            if ({cpu_rvalid, cpu_rdata} !== {1'b1, 32'hA1}) begin
               tests_failed++; $display("FAIL midrst_new: rvalid %b data %h want 1 a1", cpu_rvalid, cpu_rdata);
            end
         end else if (cpu_rvalid !== 1'b0) begin
            tests_failed++; $display("FAIL midrst_drop%0d: cpu_rvalid %b want 0", k, cpu_rvalid);
         end
         advance();
      end
   endtask

   task automatic test_random();
      logic cg, dg;
      idle();
      for (int k = 0; k < 600; k++) begin
         settle();
         tests_run++;
         if ({cpu_gnt, dma_gnt, cpu_stall} !== {exp_cg, exp_dg, exp_stall}) begin
            tests_failed++; $display("FAIL rnd_gnt@%0d: gnt/stall %b want %b", cyc, {cpu_gnt, dma_gnt, cpu_stall}, {exp_cg, exp_dg, exp_stall});
         end
         tests_run++;
         if ({cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata} !== {exp_crv, exp_drv, exp_crd, exp_drd}) begin
            tests_failed++; $display("FAIL rnd_ret@%0d: rv %b%b data %h %h want %b%b %h %h", cyc, cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata, exp_crv, exp_drv, exp_crd, exp_drd);
         end
         tests_run++;
         if ({mem_en, mem_we, mem_addr, mem_wdata} !== {exp_men, exp_mwe, exp_maddr, exp_mwd}) begin
            tests_failed++; $display("FAIL rnd_cmd@%0d: en %b we %b addr %h wd %h want %b %b %h %h", cyc, mem_en, mem_we, mem_addr, mem_wdata, exp_men, exp_mwe, exp_maddr, exp_mwd);
         end
         cg = exp_cg; dg = exp_dg;
         advance();
         if (!cpu_req || cg) begin
            cpu_req = ($urandom_range(0, 99) < 65);
            cpu_we = $urandom_range(0, 1) == 1;
            cpu_addr = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3)) | ($urandom & 32'hFFFF_F000);
            cpu_wdata = $urandom;
         end
         if (!dma_req || dg) begin
            dma_req = ($urandom_range(0, 99) < 50);
            dma_we = $urandom_range(0, 1) == 1;
            dma_addr = AW'($urandom_range(0, 15));
            dma_wdata = $urandom;
         end
      end
      idle();
   endtask

   initial begin
      tests_run = 0; tests_failed = 0; cyc = 0;
      mem_rdata = '0;
      for (int i = 0; i < 1024; i++) begin ram[i] = '0; gold[i] = '0; end
      model_reset();
      test_reset();
      test_store_load();
      test_dma_burst();
      test_contention();
      test_starvation();
      test_interleave();
      test_reset_midload();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
